// File: rtl/cmd_pkg.sv
// Shared types for the SD CMD scheduler.
// FSM states, result codes and requester ids.
package cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_IDX_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_AUTO = 1'b1
    } owner_t;

    // Bits needed to count 0..max_retry, never less than one.
    function automatic int retry_width(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Wait-cycle counter for the CMD scheduler.
// Flags the last cycle before a timeout.
module cmd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Clear on issue, count while waiting for CMD.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire = (r_count == LAST);

endmodule

// File: rtl/cmd_scheduler.sv
// Arbitrates host/auto requests onto the CMD block.
// Issues, waits, retries on timeout, reports result.
module cmd_scheduler
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 2,
    parameter int CNT_W          = 13
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         host_req,
    input  logic [31:0]  host_argument,
    input  logic [5:0]   host_index,
    output logic         host_ack,
    output logic         host_done,
    input  logic         auto_req,
    input  logic [31:0]  auto_argument,
    input  logic [5:0]   auto_index,
    output logic         auto_ack,
    output logic         auto_done,
    output logic [1:0]   status,
    output logic [127:0] response,
    output logic         busy,
    output logic         cmd_new_command,
    output logic [31:0]  cmd_argument,
    output logic [5:0]   cmd_index,
    output logic         cmd_timeout_enable,
    input  logic         cmd_command_complete,
    input  logic         cmd_command_index_error,
    input  logic [127:0] cmd_response
);

    localparam int RETRY_W = retry_width(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t               r_state;
    state_t               w_state_nxt;
    owner_t               r_owner;
    logic [RETRY_W-1:0]   r_retry;
    logic [31:0]          r_cmd_argument;
    logic [5:0]           r_cmd_index;
    logic [1:0]           r_status;
    logic [127:0]         r_response;
    logic                 w_cnt_clear;
    logic                 w_cnt_en;
    logic                 w_expire;
    logic                 w_can_retry;

    cmd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_tmo (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_cnt_clear),
        .i_enable(w_cnt_en),
        .o_expire(w_expire)
    );

    assign w_can_retry = (r_retry < RETRY_MAX);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state strobes; auto wins arbitration.
    always_comb begin
        w_state_nxt        = r_state;
        host_ack           = 1'b0;
        auto_ack           = 1'b0;
        host_done          = 1'b0;
        auto_done          = 1'b0;
        cmd_new_command    = 1'b0;
        cmd_timeout_enable = 1'b0;
        w_cnt_clear        = 1'b0;
        w_cnt_en           = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!reset && auto_req) begin
                    auto_ack    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (!reset && host_req) begin
                    host_ack    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_new_command    = 1'b1;
                cmd_timeout_enable = 1'b1;
                w_cnt_clear        = 1'b1;
                w_state_nxt        = S_WAIT;
            end
            S_WAIT: begin
                cmd_timeout_enable = 1'b1;
                w_cnt_en           = 1'b1;
                if (cmd_command_index_error || cmd_command_complete) begin
                    w_state_nxt = S_DONE;
                end else if (w_expire) begin
                    w_state_nxt = w_can_retry ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: begin
                host_done   = (r_owner == OWN_HOST);
                auto_done   = (r_owner == OWN_AUTO);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the granted command and record the outcome of WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner        <= OWN_HOST;
            r_retry        <= '0;
            r_cmd_argument <= '0;
            r_cmd_index    <= '0;
            r_status       <= ST_OK;
            r_response     <= '0;
        end else begin
            if (auto_ack) begin
                r_owner        <= OWN_AUTO;
                r_retry        <= '0;
                r_cmd_argument <= auto_argument;
                r_cmd_index    <= auto_index;
            end else if (host_ack) begin
                r_owner        <= OWN_HOST;
                r_retry        <= '0;
                r_cmd_argument <= host_argument;
                r_cmd_index    <= host_index;
            end
            if (r_state == S_WAIT) begin
                if (cmd_command_index_error) begin
                    r_status <= ST_IDX_ERR;
                end else if (cmd_command_complete) begin
                    r_status   <= ST_OK;
                    r_response <= cmd_response;
                end else if (w_expire) begin
                    if (w_can_retry) begin
                        r_retry <= r_retry + RETRY_W'(1);
                    end else begin
                        r_status <= ST_TIMEOUT;
                    end
                end
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign cmd_argument = r_cmd_argument;
    assign cmd_index    = r_cmd_index;
    assign status       = r_status;
    assign response     = r_response;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler.
// TIMEOUT_CYCLES=16, MAX_RETRY=2.
module tb_cmd_scheduler;
    import cmd_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         host_req;
    logic [31:0]  host_argument;
    logic [5:0]   host_index;
    logic         host_ack;
    logic         host_done;
    logic         auto_req;
    logic [31:0]  auto_argument;
    logic [5:0]   auto_index;
    logic         auto_ack;
    logic         auto_done;
    logic [1:0]   status;
    logic [127:0] response;
    logic         busy;
    logic         cmd_new_command;
    logic [31:0]  cmd_argument;
    logic [5:0]   cmd_index;
    logic         cmd_timeout_enable;
    logic         cmd_command_complete;
    logic         cmd_command_index_error;
    logic [127:0] cmd_response;

    int tests = 0;
    int fails = 0;
    logic [127:0] last_resp;

    always #5 clock = ~clock;

    cmd_scheduler #(
        .TIMEOUT_CYCLES(16),
        .MAX_RETRY     (2),
        .CNT_W         (5)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .host_req               (host_req),
        .host_argument          (host_argument),
        .host_index             (host_index),
        .host_ack               (host_ack),
        .host_done              (host_done),
        .auto_req               (auto_req),
        .auto_argument          (auto_argument),
        .auto_index             (auto_index),
        .auto_ack               (auto_ack),
        .auto_done              (auto_done),
        .status                 (status),
        .response               (response),
        .busy                   (busy),
        .cmd_new_command        (cmd_new_command),
        .cmd_argument           (cmd_argument),
        .cmd_index              (cmd_index),
        .cmd_timeout_enable     (cmd_timeout_enable),
        .cmd_command_complete   (cmd_command_complete),
        .cmd_command_index_error(cmd_command_index_error),
        .cmd_response           (cmd_response)
    );

    task automatic test_reset();
        reset = 1'b1;
        host_req = 0; auto_req = 0;
        host_argument = 0; host_index = 0;
        auto_argument = 0; auto_index = 0;
        cmd_command_complete = 0; cmd_command_index_error = 0;
        cmd_response = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        tests++;
        if ({busy, cmd_new_command, cmd_timeout_enable, host_ack,
             host_done, auto_ack, auto_done} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                {busy, cmd_new_command, cmd_timeout_enable, host_ack,
                 host_done, auto_ack, auto_done});
        end
        tests++;
        if (status !== 2'b00 || response !== 128'h0 ||
            cmd_argument !== 32'h0 || cmd_index !== 6'h0) begin
            fails++;
            $display("FAIL reset_data: st=%b resp=%h arg=%h idx=%h want all 0",
                status, response, cmd_argument, cmd_index);
        end
    endtask

    task automatic test_basic_host();
        int extra;
        logic [127:0] r;
        r = 128'h0000_0000_0000_0000_0000_0000_0000_01AA;
        @(negedge clock);
        host_req = 1; host_argument = 32'h0000_01AA; host_index = 6'd8;
        #1;
        tests++;
        if ({host_ack, auto_ack} !== 2'b10) begin
            fails++;
            $display("FAIL basic_ack: got %b want 10", {host_ack, auto_ack});
        end
        @(negedge clock);
        host_req = 0;
        #1;
        tests++;
        if (cmd_new_command !== 1'b1 || cmd_argument !== 32'h1AA ||
            cmd_index !== 6'd8 || host_ack !== 1'b0 ||
            cmd_timeout_enable !== 1'b1) begin
            fails++;
            $display("FAIL basic_issue: nc=%b arg=%h idx=%0d ack=%b te=%b want 1 1aa 8 0 1",
                cmd_new_command, cmd_argument, cmd_index, host_ack,
                cmd_timeout_enable);
        end
        extra = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            #1;
            if (cmd_new_command || host_done || !busy) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL basic_wait: got %0d stray events want 0", extra);
        end
        @(negedge clock);
        cmd_command_complete = 1; cmd_response = r;
        @(negedge clock);
        cmd_command_complete = 0; cmd_response = '1;
        #1;
        tests++;
        if (host_done !== 1'b1 || auto_done !== 1'b0 ||
            status !== ST_OK || response !== r) begin
            fails++;
            $display("FAIL basic_done: hd=%b ad=%b st=%b resp=%h want 1 0 00 %h",
                host_done, auto_done, status, response, r);
        end
        @(negedge clock);
        #1;
        tests++;
        if (busy !== 1'b0 || host_done !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle: busy=%b hd=%b want 0 0", busy, host_done);
        end
        last_resp = r;
    endtask

    task automatic test_simultaneous();
        logic [127:0] r2, r3;
        r2 = {96'h0, 32'hA0A0_0012};
        r3 = {32'hDEAD_BEEF, 64'h0, 32'h0000_0017};
        @(negedge clock);
        host_req = 1; host_argument = 32'h1111_2222; host_index = 6'd17;
        auto_req = 1; auto_argument = 32'h0000_0000; auto_index = 6'd12;
        #1;
        tests++;
        if ({auto_ack, host_ack} !== 2'b10) begin
            fails++;
            $display("FAIL simul_ack: got %b want 10", {auto_ack, host_ack});
        end
        @(negedge clock);
        auto_req = 0;
        #1;
        tests++;
        if (cmd_new_command !== 1'b1 || cmd_index !== 6'd12 ||
            host_ack !== 1'b0) begin
            fails++;
            $display("FAIL simul_issue1: nc=%b idx=%0d hack=%b want 1 12 0",
                cmd_new_command, cmd_index, host_ack);
        end
        @(negedge clock);
        cmd_command_complete = 1; cmd_response = r2;
        @(negedge clock);
        cmd_command_complete = 0;
        #1;
        tests++;
        if (auto_done !== 1'b1 || host_done !== 1'b0 ||
            host_ack !== 1'b0 || response !== r2) begin
            fails++;
            $display("FAIL simul_auto_done: ad=%b hd=%b hack=%b resp=%h want 1 0 0 %h",
                auto_done, host_done, host_ack, response, r2);
        end
        @(negedge clock);
        #1;
        tests++;
        if (host_ack !== 1'b1) begin
            fails++;
            $display("FAIL simul_host_ack: got %b want 1", host_ack);
        end
        @(negedge clock);
        host_req = 0;
        #1;
        tests++;
        if (cmd_new_command !== 1'b1 || cmd_index !== 6'd17 ||
            cmd_argument !== 32'h1111_2222) begin
            fails++;
            $display("FAIL simul_issue2: nc=%b idx=%0d arg=%h want 1 17 11112222",
                cmd_new_command, cmd_index, cmd_argument);
        end
        @(negedge clock);
        cmd_command_complete = 1; cmd_response = r3;
        @(negedge clock);
        cmd_command_complete = 0;
        #1;
        tests++;
        if (host_done !== 1'b1 || auto_done !== 1'b0 || response !== r3) begin
            fails++;
            $display("FAIL simul_host_done: hd=%b ad=%b resp=%h want 1 0 %h",
                host_done, auto_done, response, r3);
        end
        last_resp = r3;
    endtask

    task automatic test_index_error();
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            host_req = 1; host_argument = 32'h5; host_index = 6'd5;
            @(negedge clock);
            host_req = 0;
            @(negedge clock);
            cmd_command_index_error = 1;
            cmd_command_complete = (k == 1);
            cmd_response = {4{32'hBAD0_0000 | k}};
            @(negedge clock);
            cmd_command_index_error = 0; cmd_command_complete = 0;
            #1;
            tests++;
            if (host_done !== 1'b1 || status !== ST_IDX_ERR ||
                response !== last_resp) begin
                fails++;
                $display("FAIL idx_err_%0d: hd=%b st=%b resp=%h want 1 01 %h",
                    k, host_done, status, response, last_resp);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_timeout_retry();
        int pulses, done_c;
        int t[3];
        t = '{-1000, -1000, -1000};
        pulses = 0; done_c = -1;
        @(negedge clock);
        host_req = 1; host_argument = 32'h77; host_index = 6'd18;
        for (int c = 0; c < 100 && done_c < 0; c++) begin
            @(negedge clock);
            host_req = 0;
            #1;
            if (cmd_new_command === 1'b1) begin
                if (pulses < 3) t[pulses] = c;
                pulses++;
            end
            if (host_done === 1'b1) done_c = c;
        end
        tests++;
        if (pulses !== 3) begin
            fails++;
            $display("FAIL tmo_pulses: got %0d want 3", pulses);
        end
        tests++;
        if (t[1] - t[0] !== 17 || t[2] - t[1] !== 17) begin
            fails++;
            $display("FAIL tmo_spacing: got %0d,%0d want 17,17",
                t[1] - t[0], t[2] - t[1]);
        end
        tests++;
        if (done_c !== 51 || status !== ST_TIMEOUT) begin
            fails++;
            $display("FAIL tmo_done: cycle=%0d st=%b want 51 10", done_c, status);
        end
        @(negedge clock);

        pulses = 0; done_c = -1;
        host_req = 1; host_argument = 32'h78; host_index = 6'd19;
        for (int c = 0; c < 100 && done_c < 0; c++) begin
            @(negedge clock);
            host_req = 0;
            cmd_command_complete = (c == 19);
            cmd_response = {4{32'h0002_0002}};
            #1;
            if (cmd_new_command === 1'b1) pulses++;
            if (host_done === 1'b1) done_c = c;
        end
        cmd_command_complete = 0;
        tests++;
        if (pulses !== 2 || done_c !== 20 || status !== ST_OK ||
            response !== {4{32'h0002_0002}}) begin
            fails++;
            $display("FAIL retry_ok: pulses=%0d cycle=%0d st=%b want 2 20 00",
                pulses, done_c, status);
        end
        last_resp = response;
        @(negedge clock);
    endtask

    task automatic test_boundary();
        int pulses, done_c;
        pulses = 0; done_c = -1;
        @(negedge clock);
        host_req = 1; host_argument = 32'h99; host_index = 6'd20;
        for (int c = 0; c < 60 && done_c < 0; c++) begin
            @(negedge clock);
            host_req = 0;
            cmd_command_complete = (c == 16);
            cmd_response = {4{32'hB0B0_0016}};
            #1;
            if (cmd_new_command === 1'b1) pulses++;
            if (host_done === 1'b1) done_c = c;
        end
        cmd_command_complete = 0;
        tests++;
        if (pulses !== 1 || done_c !== 17 || status !== ST_OK) begin
            fails++;
            $display("FAIL boundary: pulses=%0d cycle=%0d st=%b want 1 17 00",
                pulses, done_c, status);
        end
        tests++;
        if (response !== {4{32'hB0B0_0016}}) begin
            fails++;
            $display("FAIL boundary_resp: got %h want %h",
                response, {4{32'hB0B0_0016}});
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        @(negedge clock);
        host_req = 1; host_argument = 32'hCAFE; host_index = 6'd33;
        @(negedge clock);
        host_req = 0;
        repeat (3) @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        #1;
        tests++;
        if ({busy, cmd_new_command, cmd_timeout_enable, host_done,
             auto_done, host_ack, auto_ack} !== 7'b0 ||
            status !== 2'b00 || response !== 128'h0 ||
            cmd_argument !== 32'h0 || cmd_index !== 6'h0) begin
            fails++;
            $display("FAIL mid_reset: ctl=%b st=%b resp=%h arg=%h idx=%h want 0",
                {busy, cmd_new_command, cmd_timeout_enable, host_done,
                 auto_done, host_ack, auto_ack},
                status, response, cmd_argument, cmd_index);
        end
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            #1;
            if (host_done || auto_done || cmd_new_command || busy) stray++;
        end
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL mid_reset_quiet: got %0d events want 0", stray);
        end
        @(negedge clock);
        host_req = 1; host_argument = 32'h0000_BEEF; host_index = 6'd7;
        #1;
        tests++;
        if (host_ack !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ack: got %b want 1", host_ack);
        end
        @(negedge clock);
        host_req = 0;
        #1;
        tests++;
        if (cmd_new_command !== 1'b1 || cmd_argument !== 32'hBEEF ||
            cmd_index !== 6'd7) begin
            fails++;
            $display("FAIL post_reset_issue: nc=%b arg=%h idx=%0d want 1 beef 7",
                cmd_new_command, cmd_argument, cmd_index);
        end
        @(negedge clock);
        cmd_command_complete = 1; cmd_response = {4{32'h0000_BEEF}};
        @(negedge clock);
        cmd_command_complete = 0;
        #1;
        tests++;
        if (host_done !== 1'b1 || status !== ST_OK ||
            response !== {4{32'h0000_BEEF}}) begin
            fails++;
            $display("FAIL post_reset_done: hd=%b st=%b resp=%h want 1 00",
                host_done, status, response);
        end
        @(negedge clock);
    endtask

    initial begin
        last_resp = '0;
        test_reset();
        test_basic_host();
        test_simultaneous();
        test_index_error();
        test_timeout_retry();
        test_boundary();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
